// File: rtl/lspc_vram_cpu_port.sv
// rtl/lspc_vram_cpu_port.sv - LSPC CPU-side VRAM port: register decode, buffered write requests, read-back latch
`timescale 1ns/1ps
module lspc_vram_cpu_port #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic              CLK_24M_i,
   input  logic              RESETP_i,
   input  logic              nREG_WR_i,
   input  logic [1:0]        REG_SEL_i,
   input  logic [DATA_W-1:0] CPU_DATA_i,
   input  logic              nCPU_WR_LOW_i,
   input  logic              nCPU_WR_HIGH_i,
   input  logic              CLK_CPU_READ_LOW_i,
   input  logic              CLK_CPU_READ_HIGH_i,
   input  logic [DATA_W-1:0] VRAM_LOW_READ_i,
   input  logic [DATA_W-1:0] VRAM_HIGH_READ_i,
   output logic [ADDR_W-2:0] VRAM_ADDR_o,
   output logic              REG_VRAMADDR_MSB_o,
   output logic [DATA_W-1:0] VRAM_WRITE_o,
   output logic              nVRAM_WRITE_REQ_o,
   output logic [DATA_W-1:0] REG_VRAMMOD_o,
   output logic [DATA_W-1:0] VRAM_READ_o,
   output logic              CPU_BUSY_o,
   output logic              OVERRUN_o
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK, S_INC} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d, shadow_q, shadow_d;
   logic              shadow_full_q, shadow_full_d;
   logic [DATA_W-1:0] pend_q, pend_d, wdata_q, wdata_d;
   logic              pend_full_q, pend_full_d;
   logic [DATA_W-1:0] mod_q, mod_d, read_q, read_d;
   logic              req_n_q, req_n_d, overrun_q, overrun_d;
   logic              ack_q, rd_q;
   logic              ack_now, rd_now, ack_fall, ack_rise, rd_rise;

   // The MSB picks both the ack source and the read-back source
   assign ack_now  = addr_q[ADDR_W-1] ? nCPU_WR_HIGH_i : nCPU_WR_LOW_i;
   assign rd_now   = addr_q[ADDR_W-1] ? CLK_CPU_READ_HIGH_i : CLK_CPU_READ_LOW_i;
   assign ack_fall = ack_q & ~ack_now;
   assign ack_rise = ~ack_q & ack_now;
   assign rd_rise  = ~rd_q & rd_now;

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      shadow_d      = shadow_q;
      shadow_full_d = shadow_full_q;
      pend_d        = pend_q;
      pend_full_d   = pend_full_q;
      wdata_d       = wdata_q;
      mod_d         = mod_q;
      read_d        = read_q;
      req_n_d       = req_n_q;
      overrun_d     = overrun_q;

      case (state_q)
         S_IDLE: begin
            if (pend_full_q) begin
               wdata_d     = pend_q;
               pend_full_d = 1'b0;
               req_n_d     = 1'b0;
               state_d     = S_REQ;
            end
         end
         S_REQ: begin
            if (ack_fall) state_d = S_ACK;
         end
         S_ACK: begin
            if (ack_rise) begin
               req_n_d = 1'b1;
               state_d = S_INC;
            end
         end
         default: begin
            state_d = S_IDLE;
            if (shadow_full_q) begin
               addr_d        = shadow_q;
               shadow_full_d = 1'b0;
            end else begin
               addr_d = addr_q + ADDR_W'(mod_q);
            end
         end
      endcase

      // Register writes are applied after the FSM so they override its updates
      if (!nREG_WR_i) begin
         case (REG_SEL_i)
            2'd0: begin
               overrun_d = 1'b0;
               if ((state_q == S_IDLE && !pend_full_q) || state_q == S_INC) begin
                  addr_d        = ADDR_W'(CPU_DATA_i);
                  shadow_full_d = 1'b0;
               end else begin
                  shadow_d      = ADDR_W'(CPU_DATA_i);
                  shadow_full_d = 1'b1;
               end
            end
            2'd1: begin
               if (!pend_full_d) begin
                  pend_d      = CPU_DATA_i;
                  pend_full_d = 1'b1;
               end else begin
                  overrun_d = 1'b1;
               end
            end
            2'd2: mod_d = CPU_DATA_i;
            default: ;
         endcase
      end

      if (rd_rise && state_q == S_IDLE)
         read_d = addr_q[ADDR_W-1] ? VRAM_HIGH_READ_i : VRAM_LOW_READ_i;
   end

   always_ff @(posedge CLK_24M_i or posedge RESETP_i) begin
      if (RESETP_i) begin
         state_q       <= S_IDLE;
         addr_q        <= '0;
         shadow_q      <= '0;
         shadow_full_q <= 1'b0;
         pend_q        <= '0;
         pend_full_q   <= 1'b0;
         wdata_q       <= '0;
         mod_q         <= '0;
         read_q        <= '0;
         req_n_q       <= 1'b1;
         overrun_q     <= 1'b0;
         ack_q         <= 1'b1;
         rd_q          <= 1'b0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         shadow_q      <= shadow_d;
         shadow_full_q <= shadow_full_d;
         pend_q        <= pend_d;
         pend_full_q   <= pend_full_d;
         wdata_q       <= wdata_d;
         mod_q         <= mod_d;
         read_q        <= read_d;
         req_n_q       <= req_n_d;
         overrun_q     <= overrun_d;
         ack_q         <= ack_now;
         rd_q          <= rd_now;
      end
   end

   assign VRAM_ADDR_o        = addr_q[ADDR_W-2:0];
   assign REG_VRAMADDR_MSB_o = addr_q[ADDR_W-1];
   assign VRAM_WRITE_o       = wdata_q;
   assign nVRAM_WRITE_REQ_o  = req_n_q;
   assign REG_VRAMMOD_o      = mod_q;
   assign VRAM_READ_o        = read_q;
   assign CPU_BUSY_o         = (state_q != S_IDLE) | pend_full_q;
   assign OVERRUN_o          = overrun_q;

endmodule

// File: tb/tb_lspc_vram_cpu_port.sv
// tb/tb_lspc_vram_cpu_port.sv - scoreboard bench for lspc_vram_cpu_port with a randomized VRAM responder
`timescale 1ns/1ps
module tb_lspc_vram_cpu_port;

   logic        clk = 1'b0, rst = 1'b1;
   logic        nreg_wr = 1'b1;
   logic [1:0]  reg_sel = 2'd0;
   logic [15:0] cpu_data = 16'h0;
   logic        nwr_low = 1'b1, nwr_high = 1'b1, rd_low = 1'b0, rd_high = 1'b0;
   logic [15:0] vlow = 16'h0, vhigh = 16'h0;
   logic [14:0] vaddr;
   logic        msb, nreq, busy, ovr;
   logic [15:0] vwrite, vmod, vread;

   always #5 clk = ~clk;

   lspc_vram_cpu_port dut (
      .CLK_24M_i(clk), .RESETP_i(rst), .nREG_WR_i(nreg_wr), .REG_SEL_i(reg_sel),
      .CPU_DATA_i(cpu_data), .nCPU_WR_LOW_i(nwr_low), .nCPU_WR_HIGH_i(nwr_high),
      .CLK_CPU_READ_LOW_i(rd_low), .CLK_CPU_READ_HIGH_i(rd_high),
      .VRAM_LOW_READ_i(vlow), .VRAM_HIGH_READ_i(vhigh),
      .VRAM_ADDR_o(vaddr), .REG_VRAMADDR_MSB_o(msb), .VRAM_WRITE_o(vwrite),
      .nVRAM_WRITE_REQ_o(nreq), .REG_VRAMMOD_o(vmod), .VRAM_READ_o(vread),
      .CPU_BUSY_o(busy), .OVERRUN_o(ovr)
   );

   typedef struct packed {logic [15:0] addr; logic [15:0] data;} txn_t;
   txn_t exp_q[$];
   txn_t exp_t;
   int checks = 0, failures = 0;
   logic [15:0] m_addr = 16'h0, m_mod = 16'h0, m_read = 16'h0;
   logic        m_ovr = 1'b0;
   int phase = 0, wcnt = 0, lcnt = 0;
   logic prev_req = 1'b1, cur_msb = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Monitor and VRAM responder: pops the expected write on each request, then acks on the expected side
   always @(negedge clk) begin
      if (rst) begin
         phase = 0; nwr_low = 1'b1; nwr_high = 1'b1; prev_req = 1'b1;
      end else begin
         if (prev_req && !nreq) begin
            if (exp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_req actual=%h required=none", {msb, vaddr});
            end else begin
               exp_t = exp_q.pop_front();
               chk("req_addr", {16'h0, msb, vaddr}, {16'h0, exp_t.addr});
               chk("req_data", {16'h0, vwrite}, {16'h0, exp_t.data});
               cur_msb = exp_t.addr[15];
            end
         end
         prev_req = nreq;
         case (phase)
            0: if (!nreq) begin wcnt = $urandom_range(0, 3); lcnt = $urandom_range(0, 3); phase = 1; end
            1: if (wcnt == 0) begin
                  if (cur_msb) nwr_high = 1'b0; else nwr_low = 1'b0;
                  phase = 2;
               end else wcnt--;
            2: if (lcnt == 0) begin nwr_low = 1'b1; nwr_high = 1'b1; phase = 3; end else lcnt--;
            default: if (nreq) phase = 0;
         endcase
      end
   end

   task automatic drive(input logic [1:0] s, input logic [15:0] d);
      @(negedge clk); nreg_wr = 1'b0; reg_sel = s; cpu_data = d;
   endtask

   task automatic release_bus();
      @(negedge clk); nreg_wr = 1'b1;
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin @(negedge clk); n++; end
      while ((busy || phase != 0 || exp_q.size() != 0) && n < 300);
      if (n >= 300) begin
         checks++; failures++;
         $display("FAIL idle_timeout actual=busy%0d_pending%0d required=idle", busy, exp_q.size());
      end
      chk("idle_addr", {16'h0, msb, vaddr}, {16'h0, m_addr});
      chk("idle_overrun", {31'h0, ovr}, {31'h0, m_ovr});
   endtask

   task automatic do_addr(input logic [15:0] v);
      drive(2'd0, v); release_bus();
      m_addr = v; m_ovr = 1'b0;
      chk("addr_load", {16'h0, msb, vaddr}, {16'h0, v});
      chk("addr_clr_overrun", {31'h0, ovr}, 32'h0);
   endtask

   task automatic do_mod(input logic [15:0] v);
      drive(2'd2, v); release_bus();
      m_mod = v;
      chk("mod_load", {16'h0, vmod}, {16'h0, v});
   endtask

   // follow: 0 none, 1 VRAMADDR write, 2 VRAMMOD write, issued while a single write is in flight
   task automatic do_burst(input int k, input int follow, input logic [15:0] fv);
      logic [15:0] d;
      for (int i = 0; i < k; i++) begin
         d = 16'($urandom);
         drive(2'd1, d);
         if (i < 2) begin
            exp_q.push_back({m_addr, d});
            if (k > 1) m_addr = m_addr + m_mod;
         end else begin
            m_ovr = 1'b1;
         end
      end
      if (k == 1) begin
         if (follow == 1) begin drive(2'd0, fv); m_addr = fv; m_ovr = 1'b0; end
         else if (follow == 2) begin drive(2'd2, fv); m_mod = fv; m_addr = m_addr + m_mod; end
         else m_addr = m_addr + m_mod;
      end
      release_bus();
      wait_idle();
   endtask

   task automatic do_read(input logic busy_phase);
      logic [15:0] exp;
      @(negedge clk); vlow = 16'($urandom); vhigh = 16'($urandom) ^ 16'h5A5A;
      rd_low = 1'b1; rd_high = 1'b1;
      exp = busy_phase ? m_read : (m_addr[15] ? vhigh : vlow);
      @(negedge clk); rd_low = 1'b0; rd_high = 1'b0;
      @(negedge clk);
      m_read = exp;
      chk(busy_phase ? "read_hold" : "read_latch", {16'h0, vread}, {16'h0, exp});
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

   initial begin
      int n;
      repeat (3) @(negedge clk);
      chk("rst_req_n", {31'h0, nreq}, 32'h1);
      chk("rst_addr", {16'h0, msb, vaddr}, 32'h0);
      chk("rst_wdata", {16'h0, vwrite}, 32'h0);
      chk("rst_mod", {16'h0, vmod}, 32'h0);
      chk("rst_read", {16'h0, vread}, 32'h0);
      chk("rst_busy_ovr", {30'h0, busy, ovr}, 32'h0);
      rst = 1'b0;

      do_addr(16'h0100);
      do_mod(16'h0001);
      drive(2'd1, 16'hABCD);
      exp_q.push_back({m_addr, 16'hABCD});
      m_addr = m_addr + m_mod;
      release_bus();
      chk("lat_busy", {31'h0, busy}, 32'h1);
      chk("lat_req_cycle1", {31'h0, nreq}, 32'h1);
      @(negedge clk);
      chk("lat_req_cycle2", {31'h0, nreq}, 32'h0);
      wait_idle();
      chk("first_addr", {16'h0, msb, vaddr}, 32'h0101);

      do_addr(16'h0100);
      do_burst(2, 0, 16'h0);
      do_burst(3, 0, 16'h0);
      chk("overrun_set", {31'h0, ovr}, 32'h1);
      do_addr(16'h0200);
      do_addr(16'h7FFF); do_mod(16'h0001); do_burst(1, 0, 16'h0);
      chk("wrap_to_fast", {16'h0, msb, vaddr}, 32'h8000);
      do_addr(16'h8010); do_mod(16'hFFFF); do_burst(1, 0, 16'h0);
      chk("fast_dec", {16'h0, msb, vaddr}, 32'h800F);
      do_burst(1, 1, 16'h1234);
      do_burst(1, 2, 16'h0003);
      do_read(1'b0);
      do_addr(16'h0040);
      do_read(1'b0);

      // Read strobe while a write is in flight must not disturb the latch
      drive(2'd1, 16'h0F0F);
      exp_q.push_back({m_addr, 16'h0F0F});
      m_addr = m_addr + m_mod;
      release_bus();
      @(negedge clk);
      do_read(1'b1);
      wait_idle();

      for (int it = 0; it < 40; it++) begin
         case ($urandom_range(0, 4))
            0: do_addr(16'($urandom));
            1: do_mod(16'($urandom_range(0, 3)) | (($urandom_range(0, 3) == 0) ? 16'hFFFC : 16'h0));
            default: begin
               n = $urandom_range(1, 3);
               do_burst(n, (n == 1) ? $urandom_range(0, 2) : 0, 16'($urandom));
            end
         endcase
         if ($urandom_range(0, 3) == 0) do_read(1'b0);
      end

      // Reset while a request is outstanding
      do_addr(16'h0123);
      drive(2'd1, 16'hBEEF);
      exp_q.push_back({m_addr, 16'hBEEF});
      release_bus();
      n = 0;
      while (nreq && n < 20) begin @(negedge clk); n++; end
      chk("rst_test_req_seen", {31'h0, nreq}, 32'h0);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_req_n", {31'h0, nreq}, 32'h1);
      chk("async_rst_addr", {16'h0, msb, vaddr}, 32'h0);
      chk("async_rst_busy", {31'h0, busy}, 32'h0);
      m_addr = 16'h0; m_mod = 16'h0; m_ovr = 1'b0; m_read = 16'h0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("post_rst_req_n", {31'h0, nreq}, 32'h1);
      chk("post_rst_busy", {31'h0, busy}, 32'h0);
      chk("post_rst_queue", exp_q.size(), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
